// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the stream round-robin arbiter.
package stream_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    // Grant index width, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Round-robin priority select: first set request at or after ptr, wrapping.
module rr_prio_select import stream_arb_pkg::*; #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned IDX_W  = idx_width(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic              found_o,
    output logic [IDX_W-1:0]  idx_o
);

    // Rotate by ptr, find first set, un-rotate; folded into one wrapped scan.
    always_comb begin
        int unsigned k;
        found_o = 1'b0;
        idx_o   = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            // ptr_i < NUM_IN, so one conditional subtract is enough to wrap
            k = 32'(ptr_i) + i;
            if (k >= NUM_IN) begin
                k = k - NUM_IN;
            end
            if (!found_o && req_i[k]) begin
                found_o = 1'b1;
                idx_o   = k[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter merging NUM_IN valid/ready streams onto one output.
// A grant is held from first presentation until handshake.
// Optional: define STREAM_RR_ARBITER_OUT_REG_EN for a one-entry output register.
module stream_rr_arbiter import stream_arb_pkg::*; #(
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_W      = idx_width(NUM_IN)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_IN-1:0]                in_valid_i,
    input  logic [NUM_IN-1:0][DATA_WIDTH-1:0] in_data_i,
    output logic [NUM_IN-1:0]                in_ready_o,
    output logic                             out_valid_o,
    output logic [DATA_WIDTH-1:0]            out_data_o,
    input  logic                             out_ready_i,
    output logic [IDX_W-1:0]                 out_idx_o
);

    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      lock_idx_q, lock_idx_d;

    logic                  win_found;
    logic [IDX_W-1:0]      win_idx;
    logic [IDX_W-1:0]      sel_idx;
    logic                  arb_valid;
    logic                  arb_ready;
    logic                  arb_hs;
    logic [DATA_WIDTH-1:0] arb_data;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return (32'(idx) == NUM_IN - 1) ? '0 : idx + 1'b1;
    endfunction

    rr_prio_select #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_prio_select (
        .req_i   (in_valid_i),
        .ptr_i   (ptr_q),
        .found_o (win_found),
        .idx_o   (win_idx)
    );

    // Grant mux: locked index while waiting for handshake, else fresh winner.
    // Gated by rst_ni so nothing is offered or accepted while in reset.
    always_comb begin
        sel_idx   = (state_q == ARB_LOCKED) ? lock_idx_q : win_idx;
        arb_valid = rst_ni && ((state_q == ARB_LOCKED) ? in_valid_i[lock_idx_q] : win_found);
        arb_data  = arb_valid ? in_data_i[sel_idx] : '0;
        arb_hs    = arb_valid && arb_ready;
        in_ready_o = '0;
        if (arb_valid && arb_ready) begin
            in_ready_o[sel_idx] = 1'b1;
        end
    end

    // FSM next state, pointer and lock updates.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_idx_d = lock_idx_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (win_found) begin
                    if (arb_hs) begin
                        ptr_d = idx_inc(win_idx);
                    end else begin
                        lock_idx_d = win_idx;
                        state_d    = ARB_LOCKED;
                    end
                end
            end
            ARB_LOCKED: begin
                if (!in_valid_i[lock_idx_q]) begin
                    // Producer retracted its beat: release without moving the pointer.
                    state_d = ARB_IDLE;
                end else if (arb_hs) begin
                    ptr_d   = idx_inc(lock_idx_q);
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

`ifdef STREAM_RR_ARBITER_OUT_REG_EN
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [IDX_W-1:0]      out_idx_q;

    // Register accepts a new beat whenever it is empty or being drained.
    assign arb_ready = !out_valid_q || out_ready_i;

    // One-entry output register; contents held while full and stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
        end else if (arb_ready) begin
            out_valid_q <= arb_valid;
            out_data_q  <= arb_data;
            out_idx_q   <= arb_valid ? sel_idx : '0;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_idx_o   = out_idx_q;
`else
    assign arb_ready   = out_ready_i;
    assign out_valid_o = arb_valid;
    assign out_data_o  = arb_data;
    assign out_idx_o   = arb_valid ? sel_idx : '0;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed self-checking bench for stream_rr_arbiter (NUM_IN=4, DATA_WIDTH=32).
module tb_stream_rr_arbiter;

    logic             clk;
    logic             rst_n;
    logic [3:0]       in_valid;
    logic [3:0][31:0] in_data;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             out_ready;
    logic [1:0]       out_idx;

    int checks = 0;
    int errors = 0;

    stream_rr_arbiter #(
        .NUM_IN     (4),
        .DATA_WIDTH (32)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
        .out_idx_o   (out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data   = {32'h13, 32'h12, 32'h11, 32'h10};
        out_ready = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== 32'h0) begin
            errors++; $display("FAIL reset_data: got %h want 0", out_data);
        end
        checks++;
        if (out_idx !== 2'd0) begin
            errors++; $display("FAIL reset_idx: got %0d want 0", out_idx);
        end
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_in_ready: got %b want 0000", in_ready);
        end
        do_reset();
    endtask

`ifndef STREAM_RR_ARBITER_OUT_REG_EN
    task automatic test_single();
        do_reset();
        in_data   = {32'h33, 32'h2A, 32'h31, 32'h30};
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h2A || out_idx !== 2'd2) begin
            errors++;
            $display("FAIL single_out: got v=%b d=%h i=%0d want v=1 d=2a i=2",
                     out_valid, out_data, out_idx);
        end
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++; $display("FAIL single_in_ready: got %b want 0100", in_ready);
        end
        step();
        // Pointer now 3: with reqs 0 and 3 pending, 3 must win.
        in_valid = 4'b1001;
        @(negedge clk);
        checks++;
        if (out_idx !== 2'd3 || out_data !== 32'h33) begin
            errors++; $display("FAIL single_ptr3: got i=%0d d=%h want i=3 d=33", out_idx, out_data);
        end
        step();
        in_valid = '0;
    endtask

    task automatic test_rotation();
        do_reset();
        in_data   = {32'h13, 32'h12, 32'h11, 32'h10};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h10 + 32'(c % 4) || out_idx !== 2'(c % 4)) begin
                errors++;
                $display("FAIL rotation_%0d: got v=%b d=%h i=%0d want v=1 d=%h i=%0d",
                         c, out_valid, out_data, out_idx, 32'h10 + 32'(c % 4), c % 4);
            end
            step();
        end
        in_valid = '0;
    endtask

    task automatic test_lock();
        do_reset();
        in_data   = {32'h23, 32'h22, 32'h21, 32'h20};
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 2'd1 || in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL lock_wait_%0d: got v=%b i=%0d r=%b want v=1 i=1 r=0000",
                         c, out_valid, out_idx, in_ready);
            end
            step();
        end
        in_valid = 4'b0011;
        @(negedge clk);
        checks++;
        if (out_idx !== 2'd1 || out_data !== 32'h21 || in_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL lock_hold: got i=%0d d=%h r=%b want i=1 d=21 r[0]=0",
                     out_idx, out_data, in_ready);
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_idx !== 2'd1 || in_ready !== 4'b0010) begin
            errors++; $display("FAIL lock_release: got i=%0d r=%b want i=1 r=0010", out_idx, in_ready);
        end
        step();
        in_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (out_idx !== 2'd0 || out_data !== 32'h20 || in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL lock_next: got i=%0d d=%h r=%b want i=0 d=20 r=0001",
                     out_idx, out_data, in_ready);
        end
        step();
        in_valid = '0;
    endtask

    task automatic test_wrap();
        do_reset();
        in_data   = {32'h43, 32'h42, 32'h41, 32'h40};
        out_ready = 1'b1;
        in_valid  = 4'b0100;
        step();
        in_valid = 4'b1001;
        @(negedge clk);
        checks++;
        if (out_idx !== 2'd3 || out_data !== 32'h43) begin
            errors++; $display("FAIL wrap_first: got i=%0d d=%h want i=3 d=43", out_idx, out_data);
        end
        step();
        @(negedge clk);
        checks++;
        if (out_idx !== 2'd0 || out_data !== 32'h40) begin
            errors++; $display("FAIL wrap_second: got i=%0d d=%h want i=0 d=40", out_idx, out_data);
        end
        step();
        in_valid = '0;
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        in_data   = {32'h53, 32'h52, 32'h51, 32'h50};
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        step();
        in_valid = 4'b0101;
        @(negedge clk);
        checks++;
        if (out_idx !== 2'd2 || out_valid !== 1'b1) begin
            errors++; $display("FAIL midlock_locked: got i=%0d v=%b want i=2 v=1", out_idx, out_valid);
        end
        step();
        in_valid = 4'b0100;
        rst_n    = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_idx !== 2'd0 || in_ready !== 4'b0) begin
            errors++;
            $display("FAIL midlock_in_reset: got v=%b d=%h i=%0d r=%b want all 0",
                     out_valid, out_data, out_idx, in_ready);
        end
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_idx !== 2'd2 || out_data !== 32'h52 || in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL midlock_rearb: got i=%0d d=%h r=%b want i=2 d=52 r=0100",
                     out_idx, out_data, in_ready);
        end
        step();
        in_valid = '0;
    endtask

    task automatic test_valid_drop();
        do_reset();
        in_data   = {32'h63, 32'h62, 32'h61, 32'h60};
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        step();
        // Locked on 1; req 1 retracts while req 3 asks.
        in_valid = 4'b1000;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL drop_valid: got %b want 0", out_valid);
        end
        step();
        in_valid  = 4'b1001;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_idx !== 2'd0 || out_data !== 32'h60) begin
            errors++; $display("FAIL drop_ptr_kept: got i=%0d d=%h want i=0 d=60", out_idx, out_data);
        end
        step();
        in_valid = '0;
    endtask
`else
    task automatic test_outreg_rotation();
        do_reset();
        in_data   = {32'h13, 32'h12, 32'h11, 32'h10};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reg_latency: got v=%b want 0", out_valid);
        end
        for (int c = 0; c < 8; c++) begin
            step();
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h10 + 32'(c % 4) || out_idx !== 2'(c % 4)) begin
                errors++;
                $display("FAIL reg_rotation_%0d: got v=%b d=%h i=%0d want v=1 d=%h i=%0d",
                         c, out_valid, out_data, out_idx, 32'h10 + 32'(c % 4), c % 4);
            end
        end
    endtask

    task automatic test_outreg_hold();
        // Register holds 0x13 from the rotation run; pointer is back at 0.
        out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL reg_stall_ready: got %b want 0000", in_ready);
        end
        for (int c = 0; c < 2; c++) begin
            step();
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h13 || out_idx !== 2'd3 || in_ready !== 4'b0) begin
                errors++;
                $display("FAIL reg_hold_%0d: got v=%b d=%h i=%0d r=%b want v=1 d=13 i=3 r=0000",
                         c, out_valid, out_data, out_idx, in_ready);
            end
        end
        out_ready = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (out_data !== 32'h10 || out_idx !== 2'd0) begin
            errors++; $display("FAIL reg_resume: got d=%h i=%0d want d=10 i=0", out_data, out_idx);
        end
        in_valid = '0;
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
`ifndef STREAM_RR_ARBITER_OUT_REG_EN
        test_single();
        test_rotation();
        test_lock();
        test_wrap();
        test_reset_mid_lock();
        test_valid_drop();
`else
        test_outreg_rotation();
        test_outreg_hold();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
